// File: rtl/hue_operand_pipe.sv
// Hue-operand stage of the RGB->HSV datapath: picks the dominant channel,
// forms max/min/delta and the hue numerator operands over a 2-deep valid/ready pipe.
module hue_operand_pipe #(
    parameter int N    = 32,
    parameter int FRAC = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] R,
    input  logic [N-1:0] G,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic [N-1:0] c,
    output logic [N-1:0] delta,
    output logic [N-1:0] vmax,
    output logic [1:0]   sector,
    output logic         sign_delta
);

    localparam int M = N - 1;

    // Sector offsets k.0 with k in the integer field above FRAC.
    localparam logic [N-1:0] C_R = N'(6) << FRAC;
    localparam logic [N-1:0] C_G = N'(2) << FRAC;
    localparam logic [N-1:0] C_B = N'(4) << FRAC;

    logic [M-1:0] mr, mg, mb;
    logic [M-1:0] mx, mn, a_src, b_src;
    logic [1:0]   sel;

    assign mr = R[M-1:0];
    assign mg = G[M-1:0];
    assign mb = B[M-1:0];

    always_comb begin
        sel   = 2'd0;
        mx    = mr;
        a_src = mg;
        b_src = mb;
        if (mr >= mg && mr >= mb) begin
            sel   = 2'd0;
            mx    = mr;
            a_src = mg;
            b_src = mb;
        end else if (mg >= mb) begin
            sel   = 2'd1;
            mx    = mg;
            a_src = mb;
            b_src = mr;
        end else begin
            sel   = 2'd2;
            mx    = mb;
            a_src = mr;
            b_src = mg;
        end
    end

    always_comb begin
        mn = mb;
        if (mr <= mg && mr <= mb)
            mn = mr;
        else if (mg <= mb)
            mn = mg;
    end

    logic         s1_valid;
    logic [M-1:0] s1_vmax, s1_delta, s1_a_src, s1_b_src;
    logic [1:0]   s1_sector;
    logic         s2_adv, s1_adv, s1_zero;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign s1_zero  = (s1_delta == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_vmax   <= '0;
            s1_delta  <= '0;
            s1_a_src  <= '0;
            s1_b_src  <= '0;
            s1_sector <= 2'd0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_vmax   <= mx;
                s1_delta  <= mx - mn;
                s1_a_src  <= a_src;
                s1_b_src  <= b_src;
                s1_sector <= sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            a          <= '0;
            b          <= '0;
            c          <= '0;
            delta      <= '0;
            vmax       <= '0;
            sector     <= 2'd0;
            sign_delta <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            // Bubbles leave the previous data in place so outputs only move on real results.
            if (s1_valid) begin
                delta      <= {1'b0, s1_delta};
                vmax       <= {1'b0, s1_vmax};
                sector     <= s1_sector;
                sign_delta <= s1_zero;
                if (s1_zero) begin
                    a <= '0;
                    b <= '0;
                    c <= '0;
                end else begin
                    a <= {1'b0, s1_a_src};
                    b <= {1'b1, s1_b_src};
                    case (s1_sector)
                        2'd0:    c <= C_R;
                        2'd1:    c <= C_G;
                        2'd2:    c <= C_B;
                        default: c <= '0;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_hue_operand_pipe.sv
// Self-checking bench for hue_operand_pipe: directed sectors/grey/latency,
// scoreboarded random stream under backpressure, and mid-stream reset.
module tb_hue_operand_pipe;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [N-1:0]  R, G, B;
    logic [N-1:0]  a, b, c, delta, vmax;
    logic [1:0]    sector;
    logic          sign_delta;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a, b, c, d, v;
        logic [1:0]  s;
        logic        sd;
    } res_t;

    res_t exp_q[$];

    hue_operand_pipe #(.N(32), .FRAC(15)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .R(R), .G(G), .B(B),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .delta(delta), .vmax(vmax),
        .sector(sector), .sign_delta(sign_delta)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [31:0] r, input logic [31:0] g, input logic [31:0] bb);
        logic [30:0] xr, xg, xb, hi, lo;
        res_t o;
        xr = r[30:0];
        xg = g[30:0];
        xb = bb[30:0];
        lo = xr;
        if (xg < lo) lo = xg;
        if (xb < lo) lo = xb;
        if (xr >= xg && xr >= xb) begin
            hi = xr; o.s = 2'd0; o.a = {1'b0, xg}; o.b = {1'b1, xb}; o.c = 32'h0003_0000;
        end else if (xg >= xb) begin
            hi = xg; o.s = 2'd1; o.a = {1'b0, xb}; o.b = {1'b1, xr}; o.c = 32'h0001_0000;
        end else begin
            hi = xb; o.s = 2'd2; o.a = {1'b0, xr}; o.b = {1'b1, xg}; o.c = 32'h0002_0000;
        end
        o.v  = {1'b0, hi};
        o.d  = {1'b0, hi - lo};
        o.sd = (hi == lo);
        if (o.sd) begin
            o.a = '0; o.b = '0; o.c = '0;
        end
        return o;
    endfunction

    task automatic cmp_out(input string tag, input res_t e);
        chk({tag, ".a"}, a, e.a);
        chk({tag, ".b"}, b, e.b);
        chk({tag, ".c"}, c, e.c);
        chk({tag, ".delta"}, delta, e.d);
        chk({tag, ".vmax"}, vmax, e.v);
        chk({tag, ".sector"}, sector, e.s);
        chk({tag, ".sd"}, sign_delta, e.sd);
    endtask

    // One transaction with out_ready high; checks 2-cycle latency and literal results.
    task automatic directed(input string tag, input logic [31:0] r, input logic [31:0] g,
                            input logic [31:0] bb, input res_t e);
        @(posedge clk); #1;
        in_valid = 1'b1; R = r; G = g; B = bb; out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".early"}, out_valid, 0);
        @(negedge clk);
        chk({tag, ".latency"}, out_valid, 1);
        cmp_out(tag, e);
        @(negedge clk);
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    initial begin
        logic [31:0] rv[8], gv[8], bv[8];
        res_t held, e;
        bit   stalled_prev, saw_low;
        int   sent, got, cyc, seen;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; R = '0; G = '0; B = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        cmp_out("rst", '{a:0, b:0, c:0, d:0, v:0, s:0, sd:0});

        directed("rdom", 32'h0001_0000, 32'h0000_8000, 32'h0,
                 '{a:32'h0000_8000, b:32'h8000_0000, c:32'h0003_0000, d:32'h0001_0000,
                   v:32'h0001_0000, s:2'd0, sd:1'b0});
        directed("tie_rg", 32'h0001_0000, 32'h0001_0000, 32'h0,
                 '{a:32'h0001_0000, b:32'h8000_0000, c:32'h0003_0000, d:32'h0001_0000,
                   v:32'h0001_0000, s:2'd0, sd:1'b0});
        directed("tie_gb", 32'h0, 32'h0001_0000, 32'h0001_0000,
                 '{a:32'h0001_0000, b:32'h8000_0000, c:32'h0001_0000, d:32'h0001_0000,
                   v:32'h0001_0000, s:2'd1, sd:1'b0});
        directed("bdom", 32'h0000_4000, 32'h0, 32'h0001_0000,
                 '{a:32'h0000_4000, b:32'h8000_0000, c:32'h0002_0000, d:32'h0001_0000,
                   v:32'h0001_0000, s:2'd2, sd:1'b0});
        directed("grey", 32'h0000_4000, 32'h0000_4000, 32'h0000_4000,
                 '{a:0, b:0, c:0, d:0, v:32'h0000_4000, s:2'd0, sd:1'b1});
        directed("zero", 32'h0, 32'h0, 32'h0,
                 '{a:0, b:0, c:0, d:0, v:0, s:2'd0, sd:1'b1});
        // Sign bits set on input must be ignored.
        directed("signbit", 32'h8000_1000, 32'h8000_3000, 32'h8000_2000,
                 '{a:32'h0000_2000, b:32'h8000_1000, c:32'h0001_0000, d:32'h0000_2000,
                   v:32'h0000_3000, s:2'd1, sd:1'b0});

        for (int i = 0; i < 8; i++) begin
            rv[i] = $urandom;
            gv[i] = $urandom;
            bv[i] = $urandom;
        end
        rv[3] = 32'h0000_7777; gv[3] = 32'h8000_7777; bv[3] = 32'h0000_7777;

        sent = 0; got = 0; cyc = 0; stalled_prev = 0; saw_low = 0;
        while ((sent < 8 || exp_q.size() > 0) && cyc < 200) begin
            @(posedge clk); #1;
            in_valid  = (sent < 8);
            R = rv[sent % 8]; G = gv[sent % 8]; B = bv[sent % 8];
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (stalled_prev) cmp_out("stall_hold", held);
            stalled_prev = out_valid && !out_ready;
            held = '{a:a, b:b, c:c, d:delta, v:vmax, s:sector, sd:sign_delta};
            if (!in_ready) saw_low = 1;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(R, G, B));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream.extra", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    cmp_out("stream", e);
                end
                got++;
            end
            cyc++;
        end
        #1 in_valid = 1'b0;
        chk("stream.timeout", (cyc < 200), 1);
        chk("stream.count", got, 8);
        chk("stream.in_ready_drop", saw_low, 1);

        // Two in flight while stalled, then reset discards both.
        exp_q.delete();
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1;
        R = 32'h0000_1000; G = 32'h0; B = 32'h0;
        @(posedge clk); #1;
        R = 32'h0000_2000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst.loaded", out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst.flushed", seen, 0);
        cmp_out("midrst.zero", '{a:0, b:0, c:0, d:0, v:0, s:0, sd:0});
        directed("after_rst", 32'h0000_8000, 32'h0000_2000, 32'h0001_0000,
                 '{a:32'h0000_8000, b:32'h8000_2000, c:32'h0002_0000, d:32'h0000_E000,
                   v:32'h0001_0000, s:2'd2, sd:1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
